sc_randgen: RTL and testbench
=============================

Name: sc_randgen

Overview:
- Responder for the active-low load-seed / load-rand command pulses issued by the front-end control state machine.
- Holds a Galois LFSR.
- Seed pulse: loads a seed word.
- Rand pulse: advances the LFSR STEPS times, then publishes a fresh word with a one-cycle valid strobe.
- Sits between the control state machine and the display/output register of the pseudo-random unit.

Parameters:
- WIDTH, 8, LFSR and data width.
- TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1).
- SEED_DEFAULT, 8'h01, reset value and substitute for an all-zero seed (must be nonzero).
- STEPS, 8, LFSR shifts per rand request (1..255).

Ports:
- SC_RANDGEN_CLOCK_50  in  1  system clock, rising edge.
- SC_RANDGEN_RESET_InLow  in  1  reset.
- SC_RANDGEN_loadseed_InLow  in  1  seed request, active low.
- SC_RANDGEN_loadrand_InLow  in  1  rand request, active low.
- SC_RANDGEN_seed_InBUS  in  WIDTH  seed value, sampled with the seed request.
- SC_RANDGEN_data_OutBUS  out  WIDTH  last published random word, registered.
- SC_RANDGEN_valid_OutHigh  out  1  one-cycle strobe: new data_OutBUS.
- SC_RANDGEN_busy_OutHigh  out  1  high while not in IDLE (combinational from state).
- SC_RANDGEN_zeroseed_OutHigh  out  1  sticky: last seed load was zero.

Behaviour:

Clock and reset:
- One clock. Reset is asynchronous and active-low.
- Reset values: lfsr=SEED_DEFAULT, data_OutBUS=0, valid=0, zeroseed=0, cnt=0, state=IDLE, busy=0.

LFSR step (Galois, right shift):
- b = lfsr[0]; lfsr = lfsr>>1; if b, lfsr ^= TAPS.
- Step counter cnt is 8 bits.

State IDLE:
- Requests are sampled by level, only in IDLE.
- If loadseed_InLow==0: go to SEED. Seed has priority when both requests are low.
- Else if loadrand_InLow==0: go to SHIFT, cnt<=0.
- Else stay in IDLE.

State SEED (1 cycle):
- Uses the seed sampled at the IDLE edge.
- If the seed is nonzero: lfsr<=seed, zeroseed<=0.
- If the seed is zero: lfsr<=SEED_DEFAULT, zeroseed<=1.
- Next state IDLE.
- data_OutBUS is unchanged. No valid strobe.

State SHIFT:
- One LFSR step per cycle, cnt<=cnt+1.
- When the step with cnt==STEPS-1 is taken, go to PRESENT. Exactly STEPS steps are performed.

State PRESENT (1 cycle):
- data_OutBUS<=lfsr, valid<=1, next state IDLE.
- valid is cleared on every other edge, so it is high for exactly one cycle.

Latency:
- Rand request sampled at edge E0.
- data_OutBUS and valid update at edge E0+STEPS+1.
- Next request accepted at edge E0+STEPS+2.
- Seed: lfsr updated at E0+1.

Request handling:
- Requests arriving while busy are ignored; there is no queuing.
- A request held low is re-accepted each time IDLE is reached, giving back-to-back generations.

Invariant: lfsr is never zero; the zero seed is substituted on load.

Reset mid-operation:
- Any state returns immediately to IDLE.
- All outputs return to reset values; the in-flight word is discarded.

No other state is reachable. Any illegal encoding recovers to IDLE on the next edge.

Test Plan:
1. Reset, then single rand pulse -> busy high for STEPS+1=9 cycles; valid pulses once, 9 cycles after the sampling edge; data_OutBUS=0x64.
2. Second rand pulse after test 1 -> data_OutBUS=0x93, valid one cycle, no glitch on data between strobes.
3. Seed 0x00 pulse -> zeroseed=1, data unchanged, no valid; then rand pulse -> data=0x64. Then seed 0x01 -> zeroseed=0.
4. Seed and rand pulses low in the same cycle with seed 0x01 -> only seed processed (busy 1 cycle, no valid); a rand pulse during SHIFT is ignored (exactly one valid per accepted request).
5. Assert reset during SHIFT (cnt=4) -> outputs immediately 0 / busy 0 / valid 0; after release, rand pulse -> data=0x64.
6. STEPS=1, loadrand held low for 255 accepted requests from reset -> all 255 words distinct and nonzero; the 256th equals the 1st (0xB8).

Source files
------------

// File: rtl/sc_randgen_if.sv
// Command/result bundle between the front-end control FSM (master) and the
// pseudo-random generator (slave).
interface sc_randgen_if #(
  parameter int WIDTH = 8
);
  logic             SC_RANDGEN_loadseed_InLow;
  logic             SC_RANDGEN_loadrand_InLow;
  logic [WIDTH-1:0] SC_RANDGEN_seed_InBUS;
  logic [WIDTH-1:0] SC_RANDGEN_data_OutBUS;
  logic             SC_RANDGEN_valid_OutHigh;
  logic             SC_RANDGEN_busy_OutHigh;
  logic             SC_RANDGEN_zeroseed_OutHigh;

  modport master (
    output SC_RANDGEN_loadseed_InLow, SC_RANDGEN_loadrand_InLow, SC_RANDGEN_seed_InBUS,
    input  SC_RANDGEN_data_OutBUS, SC_RANDGEN_valid_OutHigh,
           SC_RANDGEN_busy_OutHigh, SC_RANDGEN_zeroseed_OutHigh
  );

  modport slave (
    input  SC_RANDGEN_loadseed_InLow, SC_RANDGEN_loadrand_InLow, SC_RANDGEN_seed_InBUS,
    output SC_RANDGEN_data_OutBUS, SC_RANDGEN_valid_OutHigh,
           SC_RANDGEN_busy_OutHigh, SC_RANDGEN_zeroseed_OutHigh
  );
endinterface

// File: rtl/sc_randgen.sv
// Galois-LFSR random word generator answering active-low seed/rand pulses;
// a rand request shifts STEPS times and then publishes one word with a strobe.
module sc_randgen #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 8'h01,
  parameter int               STEPS        = 8
) (
  input  logic          SC_RANDGEN_CLOCK_50,
  input  logic          SC_RANDGEN_RESET_InLow,
  sc_randgen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SEED, SHIFT, PRESENT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] data;
  logic [7:0]       cnt;
  logic             valid;
  logic             zeroseed;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  always_ff @(posedge SC_RANDGEN_CLOCK_50 or negedge SC_RANDGEN_RESET_InLow) begin
    if (!SC_RANDGEN_RESET_InLow) state <= IDLE;
    else                         state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (!bus.SC_RANDGEN_loadseed_InLow)      state_nxt = SEED;
        else if (!bus.SC_RANDGEN_loadrand_InLow) state_nxt = SHIFT;
        else                                     state_nxt = IDLE;
      end
      SEED:    state_nxt = IDLE;
      SHIFT:   state_nxt = (cnt == 8'(STEPS - 1)) ? PRESENT : SHIFT;
      PRESENT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SC_RANDGEN_CLOCK_50 or negedge SC_RANDGEN_RESET_InLow) begin
    if (!SC_RANDGEN_RESET_InLow) begin
      lfsr     <= SEED_DEFAULT;
      seed_q   <= '0;
      data     <= '0;
      cnt      <= '0;
      valid    <= 1'b0;
      zeroseed <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.SC_RANDGEN_loadseed_InLow)      seed_q <= bus.SC_RANDGEN_seed_InBUS;
          else if (!bus.SC_RANDGEN_loadrand_InLow) cnt    <= '0;
        end
        SEED: begin
          // A zero seed would lock the LFSR at zero forever, so substitute the default.
          if (seed_q != '0) begin
            lfsr     <= seed_q;
            zeroseed <= 1'b0;
          end else begin
            lfsr     <= SEED_DEFAULT;
            zeroseed <= 1'b1;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_step(lfsr);
          cnt  <= cnt + 8'd1;
        end
        PRESENT: begin
          data  <= lfsr;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.SC_RANDGEN_data_OutBUS      = data;
  assign bus.SC_RANDGEN_valid_OutHigh    = valid;
  assign bus.SC_RANDGEN_busy_OutHigh     = (state != IDLE);
  assign bus.SC_RANDGEN_zeroseed_OutHigh = zeroseed;

endmodule

// File: tb/tb_sc_randgen.sv
// Self-checking bench for sc_randgen: transaction-level model compared every
// cycle, directed scenarios with literal expectations, and a full-period run.
module tb_sc_randgen;

  localparam int STEPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst6_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sc_randgen_if #(.WIDTH(8)) bus ();
  sc_randgen_if #(.WIDTH(8)) bus6 ();

  sc_randgen #(.WIDTH(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .STEPS(STEPS)) dut (
    .SC_RANDGEN_CLOCK_50    (clk),
    .SC_RANDGEN_RESET_InLow (rst_n),
    .bus                    (bus)
  );

  sc_randgen #(.WIDTH(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .STEPS(1)) dut6 (
    .SC_RANDGEN_CLOCK_50    (clk),
    .SC_RANDGEN_RESET_InLow (rst6_n),
    .bus                    (bus6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Spec-level LFSR arithmetic: one Galois right-shift step applied n times.
  function automatic logic [7:0] advance(input logic [7:0] x, input int n);
    logic [7:0] v = x;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    return v;
  endfunction

  // Transaction model: a request taken while not busy occupies the unit for a
  // fixed number of edges, and its visible effect lands when that count expires.
  logic [7:0] m_lfsr, m_data, m_pend;
  logic       m_valid, m_zs, m_pend_zs, m_is_rand;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = 8'h01; m_data = 8'h00; m_valid = 1'b0; m_zs = 1'b0; m_left = 0;
      m_pend = 8'h00; m_pend_zs = 1'b0; m_is_rand = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_is_rand) begin m_data = m_pend; m_valid = 1'b1; end
          else m_zs = m_pend_zs;
        end
      end else if (!bus.SC_RANDGEN_loadseed_InLow) begin
        m_is_rand = 1'b0;
        m_pend_zs = (bus.SC_RANDGEN_seed_InBUS == 8'h00);
        m_lfsr    = m_pend_zs ? 8'h01 : bus.SC_RANDGEN_seed_InBUS;
        m_left    = 1;
      end else if (!bus.SC_RANDGEN_loadrand_InLow) begin
        m_is_rand = 1'b1;
        m_lfsr    = advance(m_lfsr, STEPS);
        m_pend    = m_lfsr;
        m_left    = STEPS + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("data",     32'(bus.SC_RANDGEN_data_OutBUS),      32'(m_data));
    check("valid",    32'(bus.SC_RANDGEN_valid_OutHigh),    32'(m_valid));
    check("busy",     32'(bus.SC_RANDGEN_busy_OutHigh),     32'(m_left > 0));
    check("zeroseed", 32'(bus.SC_RANDGEN_zeroseed_OutHigh), 32'(m_zs));
  end

  // One-cycle active-low pulse, then watch up to `limit` negedges; returns how many
  // of them showed busy, the edge offset of the first strobe, and the strobe count.
  task automatic pulse(input bit do_seed, input bit do_rand, input logic [7:0] seed,
                       input int limit, output int busy_n, output int valid_edge,
                       output int valid_n);
    busy_n = 0; valid_edge = -1; valid_n = 0;
    @(negedge clk); #1;
    bus.SC_RANDGEN_seed_InBUS = seed;
    if (do_seed) bus.SC_RANDGEN_loadseed_InLow = 1'b0;
    if (do_rand) bus.SC_RANDGEN_loadrand_InLow = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (bus.SC_RANDGEN_busy_OutHigh) busy_n++;
      if (bus.SC_RANDGEN_valid_OutHigh) begin
        valid_n++;
        if (valid_edge < 0) valid_edge = k - 1;
      end
      if (k == 1) begin
        #1;
        bus.SC_RANDGEN_loadseed_InLow = 1'b1;
        bus.SC_RANDGEN_loadrand_InLow = 1'b1;
      end
      if (valid_edge >= 0 && k > valid_edge + 2) break;
    end
  endtask

  int         busy_n, vedge, vn;
  logic [7:0] words [256];
  bit         seen  [256];

  initial begin
    bus.SC_RANDGEN_loadseed_InLow  = 1'b1;
    bus.SC_RANDGEN_loadrand_InLow  = 1'b1;
    bus.SC_RANDGEN_seed_InBUS      = 8'h00;
    bus6.SC_RANDGEN_loadseed_InLow = 1'b1;
    bus6.SC_RANDGEN_loadrand_InLow = 1'b1;
    bus6.SC_RANDGEN_seed_InBUS     = 8'h00;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    check("reset_data", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h00);
    check("reset_busy", 32'(bus.SC_RANDGEN_busy_OutHigh), 32'h0);
    check("model_pin_8steps", 32'(advance(8'h01, 8)), 32'h64);

    // 1: first rand word
    pulse(1'b0, 1'b1, 8'h00, 40, busy_n, vedge, vn);
    check("t1_busy_cycles", 32'(busy_n), 32'd9);
    check("t1_valid_edge",  32'(vedge), 32'd9);
    check("t1_valid_count", 32'(vn), 32'd1);
    check("t1_data", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h64);

    // 2: second rand word
    pulse(1'b0, 1'b1, 8'h00, 40, busy_n, vedge, vn);
    check("t2_valid_count", 32'(vn), 32'd1);
    check("t2_data", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h93);

    // 3: zero seed substitution, then reseed with 1
    pulse(1'b1, 1'b0, 8'h00, 6, busy_n, vedge, vn);
    check("t3_zs", 32'(bus.SC_RANDGEN_zeroseed_OutHigh), 32'h1);
    check("t3_no_valid", 32'(vn), 32'd0);
    check("t3_data_kept", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h93);
    pulse(1'b0, 1'b1, 8'h00, 40, busy_n, vedge, vn);
    check("t3_rand_data", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h64);
    pulse(1'b1, 1'b0, 8'h01, 6, busy_n, vedge, vn);
    check("t3_zs_clear", 32'(bus.SC_RANDGEN_zeroseed_OutHigh), 32'h0);

    // 4: simultaneous requests -> seed only; rand during SHIFT is dropped
    pulse(1'b1, 1'b1, 8'h01, 6, busy_n, vedge, vn);
    check("t4_busy_cycles", 32'(busy_n), 32'd1);
    check("t4_no_valid", 32'(vn), 32'd0);
    fork
      pulse(1'b0, 1'b1, 8'h00, 30, busy_n, vedge, vn);
      begin
        repeat (4) @(negedge clk); #1;
        bus.SC_RANDGEN_loadrand_InLow = 1'b0;
        @(negedge clk); #1;
        bus.SC_RANDGEN_loadrand_InLow = 1'b1;
      end
    join
    check("t4_one_valid", 32'(vn), 32'd1);
    check("t4_data", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h64);
    repeat (12) @(negedge clk);
    check("t4_idle_after", 32'(bus.SC_RANDGEN_busy_OutHigh), 32'h0);

    // 5: reset in the middle of SHIFT (cnt==4)
    @(negedge clk); #1 bus.SC_RANDGEN_loadrand_InLow = 1'b0;
    @(negedge clk); #1 bus.SC_RANDGEN_loadrand_InLow = 1'b1;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_data",  32'(bus.SC_RANDGEN_data_OutBUS), 32'h00);
    check("t5_rst_busy",  32'(bus.SC_RANDGEN_busy_OutHigh), 32'h0);
    check("t5_rst_valid", 32'(bus.SC_RANDGEN_valid_OutHigh), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    pulse(1'b0, 1'b1, 8'h00, 40, busy_n, vedge, vn);
    check("t5_valid_count", 32'(vn), 32'd1);
    check("t5_data", 32'(bus.SC_RANDGEN_data_OutBUS), 32'h64);

    // 6: STEPS=1 instance, rand held low -> full LFSR period
    @(negedge clk); #1;
    rst6_n = 1'b1;
    bus6.SC_RANDGEN_loadrand_InLow = 1'b0;
    begin
      int got = 0;
      int budget = 0;
      while (got < 256 && budget < 2000) begin
        @(negedge clk);
        budget++;
        if (bus6.SC_RANDGEN_valid_OutHigh) begin
          words[got] = bus6.SC_RANDGEN_data_OutBUS;
          got++;
        end
      end
      bus6.SC_RANDGEN_loadrand_InLow = 1'b1;
      check("t6_word_count", 32'(got), 32'd256);
      if (got == 256) begin
        int distinct_ok = 1;
        int nonzero_ok = 1;
        check("t6_first", 32'(words[0]), 32'hB8);
        for (int i = 0; i < 255; i++) begin
          if (words[i] == 8'h00) nonzero_ok = 0;
          if (seen[words[i]]) distinct_ok = 0;
          seen[words[i]] = 1'b1;
        end
        check("t6_nonzero", 32'(nonzero_ok), 32'd1);
        check("t6_distinct", 32'(distinct_ok), 32'd1);
        check("t6_wrap", 32'(words[255]), 32'(words[0]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
